// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Definitions shared by the async FIFO and the blocks in front
//               of it.
//                 DSIZE/ASIZE : default data and address widths of the FIFO
//                 arb_state_t : write-arbiter state encoding
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int DSIZE = 8;
    localparam int ASIZE = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin selector. It returns the first set
//               bit of i_req, searching i_ptr, i_ptr+1, ... (mod NREQ).
//               Ports:
//                 i_req   [NREQ]   request vector
//                 i_ptr   [IW]     index where the search starts (< NREQ)
//                 o_found          at least one request is set
//                 o_idx   [IW]     index of the selected request
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         i_req,
    input  logic [$clog2(NREQ)-1:0] i_ptr,
    output logic                    o_found,
    output logic [$clog2(NREQ)-1:0] o_idx
);

    localparam int IW = $clog2(NREQ);
    localparam logic [IW:0] c_NREQ = (IW+1)'(NREQ);

    logic [2*NREQ-1:0] w_dbl;
    logic [NREQ-1:0]   w_rot;
    logic [IW-1:0]     w_off;
    logic [IW:0]       w_sum;

    // Rotate: bit k of w_rot is request (ptr + k) mod NREQ.
    assign w_dbl = {i_req, i_req};
    assign w_rot = w_dbl[i_ptr +: NREQ];

    // Priority-encode the rotated vector, lowest offset wins.
    always_comb begin
        w_off = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = IW'(k);
            end
        end
    end

    // Unrotate with an explicit wrap, since NREQ need not be a power of two.
    assign w_sum   = {1'b0, i_ptr} + {1'b0, w_off};
    assign o_idx   = (w_sum >= c_NREQ) ? IW'(w_sum - c_NREQ) : w_sum[IW-1:0];
    assign o_found = |i_req;

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Round-robin sharing of the FIFO write port among NREQ
//               producers. A grant lasts up to BURST words. Each requester
//               uses a valid/ready handshake, and only wfull stalls it.
//               Ports:
//                 wclk, wrst       write clock, sync active-high reset
//                 req_valid/data   per-requester word offers
//                 req_ready        one-hot (or zero) accept
//                 arb_en           gate for new grants (sampled in IDLE)
//                 wfull            FIFO full flag
//                 winc, wdata      FIFO write strobe and data
//                 busy, gnt_id     grant active, current/last grantee
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int DSIZE = fifo_pkg::DSIZE,
    parameter int NREQ  = 4,
    parameter int BURST = 4
) (
    input  logic                    wclk,
    input  logic                    wrst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*DSIZE-1:0]   req_data,
    output logic [NREQ-1:0]         req_ready,
    input  logic                    arb_en,
    input  logic                    wfull,
    output logic                    winc,
    output logic [DSIZE-1:0]        wdata,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] gnt_id
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(BURST + 1);
    localparam logic [CW-1:0] c_LAST = CW'(BURST - 1);
    localparam logic [IW-1:0] c_TOP  = IW'(NREQ - 1);

    arb_state_t    r_state, w_state_nxt;
    logic [IW-1:0] r_ptr, w_ptr_nxt;
    logic [IW-1:0] r_gnt_id, w_gnt_id_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;

    logic             w_found;
    logic [IW-1:0]    w_pick;
    logic             w_sel_valid;
    logic             w_xfer;
    logic [DSIZE-1:0] w_lane [NREQ];

    generate
        for (genvar i = 0; i < NREQ; i++) begin : g_lane
            assign w_lane[i] = req_data[i*DSIZE +: DSIZE];
        end
    endgenerate

    rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_found (w_found),
        .o_idx   (w_pick)
    );

    always_ff @(posedge wclk) begin
        if (wrst) begin
            r_state  <= IDLE;
            r_ptr    <= '0;
            r_gnt_id <= '0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_ptr    <= w_ptr_nxt;
            r_gnt_id <= w_gnt_id_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    assign w_sel_valid = req_valid[r_gnt_id];
    assign w_xfer      = (r_state == GRANT) && w_sel_valid && !wfull;

    always_comb begin
        w_state_nxt  = r_state;
        w_ptr_nxt    = r_ptr;
        w_gnt_id_nxt = r_gnt_id;
        w_cnt_nxt    = r_cnt;
        req_ready    = '0;
        winc         = 1'b0;
        wdata        = '0;

        case (r_state)
            IDLE: begin
                if (arb_en && w_found) begin
                    w_gnt_id_nxt = w_pick;
                    w_cnt_nxt    = '0;
                    w_state_nxt  = GRANT;
                end
            end

            GRANT: begin
                // Ready follows only back-pressure; a requester that is not
                // valid is released below without writing.
                req_ready[r_gnt_id] = !wfull;
                winc                = w_xfer;
                if (w_xfer) begin
                    wdata     = w_lane[r_gnt_id];
                    w_cnt_nxt = r_cnt + CW'(1);
                end
                // Release on a dropped valid (even while stalled) or on the
                // last word of the burst. A full FIFO with valid held stalls.
                if (!w_sel_valid || (w_xfer && (r_cnt == c_LAST))) begin
                    w_ptr_nxt   = (r_gnt_id == c_TOP) ? '0 : r_gnt_id + IW'(1);
                    w_state_nxt = IDLE;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign busy   = (r_state == GRANT);
    assign gnt_id = r_gnt_id;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wr_arbiter
// Description : Directed, table-driven bench for fifo_wr_arbiter with
//               NREQ=4, BURST=4, DSIZE=8, plus a hand-written single-producer
//               stream sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    logic        wclk = 1'b0;
    logic        wrst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        arb_en;
    logic        wfull;
    logic        winc;
    logic [7:0]  wdata;
    logic        busy;
    logic [1:0]  gnt_id;

    fifo_wr_arbiter #(
        .DSIZE (8),
        .NREQ  (4),
        .BURST (4)
    ) dut (
        .wclk      (wclk),
        .wrst      (wrst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .arb_en    (arb_en),
        .wfull     (wfull),
        .winc      (winc),
        .wdata     (wdata),
        .busy      (busy),
        .gnt_id    (gnt_id)
    );

    always #5 wclk = ~wclk;

    typedef struct {
        logic       rst;
        logic       en;
        logic       full;
        logic [3:0] val;
        logic       e_winc;
        logic [3:0] e_rdy;
        logic [7:0] e_wd;
        logic       e_busy;
        logic [1:0] e_gnt;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic vn(input int n, input logic r, input logic en, input logic f,
                      input logic [3:0] val, input logic wi, input logic [3:0] rd,
                      input logic [7:0] wd, input logic b, input logic [1:0] g);
        vec_t t;
        t.rst = r; t.en = en; t.full = f; t.val = val;
        t.e_winc = wi; t.e_rdy = rd; t.e_wd = wd; t.e_busy = b; t.e_gnt = g;
        for (int i = 0; i < n; i++) tbl.push_back(t);
    endtask

    int exp_cyc [10] = '{1, 2, 3, 4, 6, 7, 8, 9, 11, 12};

    initial begin
        int   n_winc;
        int   n_hs;
        int   exp_winc;
        int   nw;
        int   k;
        logic hs;
        logic [7:0] wd_q [10];
        int         wc_q [10];

        wrst      = 1'b1;
        req_valid = 4'hF;
        arb_en    = 1'b1;
        wfull     = 1'b0;
        req_data  = {8'h44, 8'h33, 8'h22, 8'h11};

        // Reset held two edges with every requester valid.
        repeat (2) @(posedge wclk);
        @(negedge wclk);
        cmp("rst_winc", 32'(winc), 32'd0);
        cmp("rst_ready", 32'(req_ready), 32'd0);
        cmp("rst_busy", 32'(busy), 32'd0);
        cmp("rst_gnt", 32'(gnt_id), 32'd0);
        @(posedge wclk);
        #1;

        // Round robin over all four, wrap 3->0.
        vn(1, 1, 1, 0, 4'hF, 0, 4'b0000, 8'h00, 0, 0);
        vn(1, 0, 1, 0, 4'hF, 0, 4'b0000, 8'h00, 0, 0);
        vn(4, 0, 1, 0, 4'hF, 1, 4'b0001, 8'h11, 1, 0);
        vn(1, 0, 1, 0, 4'hF, 0, 4'b0000, 8'h00, 0, 0);
        vn(4, 0, 1, 0, 4'hF, 1, 4'b0010, 8'h22, 1, 1);
        vn(1, 0, 1, 0, 4'hF, 0, 4'b0000, 8'h00, 0, 1);
        vn(4, 0, 1, 0, 4'hF, 1, 4'b0100, 8'h33, 1, 2);
        vn(1, 0, 1, 0, 4'hF, 0, 4'b0000, 8'h00, 0, 2);
        vn(4, 0, 1, 0, 4'hF, 1, 4'b1000, 8'h44, 1, 3);
        vn(1, 0, 1, 0, 4'hF, 0, 4'b0000, 8'h00, 0, 3);
        vn(4, 0, 1, 0, 4'hF, 1, 4'b0001, 8'h11, 1, 0);
        vn(1, 0, 1, 0, 4'hF, 0, 4'b0000, 8'h00, 0, 0);
        // Early release: req 1 drops valid after one word; req 2 wins over req 0.
        vn(1, 0, 1, 0, 4'hF,    1, 4'b0010, 8'h22, 1, 1);
        vn(1, 0, 1, 0, 4'b1101, 0, 4'b0010, 8'h00, 1, 1);
        vn(1, 0, 1, 0, 4'b1101, 0, 4'b0000, 8'h00, 0, 1);
        // Stall of 5 cycles after 2 words, then words 3-4.
        vn(2, 0, 1, 0, 4'b1101, 1, 4'b0100, 8'h33, 1, 2);
        vn(5, 0, 1, 1, 4'b1101, 0, 4'b0000, 8'h00, 1, 2);
        vn(2, 0, 1, 0, 4'b1101, 1, 4'b0100, 8'h33, 1, 2);
        // arb_en low in IDLE blocks new grants.
        vn(2, 0, 0, 0, 4'hF, 0, 4'b0000, 8'h00, 0, 2);
        vn(1, 0, 1, 0, 4'hF, 0, 4'b0000, 8'h00, 0, 2);
        vn(1, 0, 1, 0, 4'hF, 1, 4'b1000, 8'h44, 1, 3);
        // arb_en low mid-burst: burst completes, then stays idle.
        vn(3, 0, 0, 0, 4'hF, 1, 4'b1000, 8'h44, 1, 3);
        vn(2, 0, 0, 0, 4'hF, 0, 4'b0000, 8'h00, 0, 3);
        vn(1, 0, 1, 0, 4'b1110, 0, 4'b0000, 8'h00, 0, 3);
        // Reset mid-burst of req 1; afterwards ptr restarts at 0 and picks 1.
        vn(1, 0, 1, 0, 4'b1110, 1, 4'b0010, 8'h22, 1, 1);
        vn(1, 1, 1, 0, 4'b1110, 1, 4'b0010, 8'h22, 1, 1);
        vn(1, 0, 1, 0, 4'b1110, 0, 4'b0000, 8'h00, 0, 0);
        vn(1, 0, 1, 0, 4'b1110, 1, 4'b0010, 8'h22, 1, 1);

        n_winc   = 0;
        n_hs     = 0;
        exp_winc = 0;
        foreach (tbl[i]) begin
            wrst      = tbl[i].rst;
            arb_en    = tbl[i].en;
            wfull     = tbl[i].full;
            req_valid = tbl[i].val;
            @(negedge wclk);
            cmp($sformatf("vec%0d {winc,ready,wdata,busy,gnt}", i),
                32'({winc, req_ready, wdata, busy, gnt_id}),
                32'({tbl[i].e_winc, tbl[i].e_rdy, tbl[i].e_wd, tbl[i].e_busy, tbl[i].e_gnt}));
            cmp($sformatf("vec%0d winc_while_full", i), 32'(winc & wfull), 32'd0);
            cmp($sformatf("vec%0d ready_onehot0", i), 32'($onehot0(req_ready)), 32'd1);
            n_winc   += int'(winc);
            n_hs     += int'(|(req_valid & req_ready));
            exp_winc += int'(tbl[i].e_winc);
            @(posedge wclk);
            #1;
        end
        cmp("total_winc", 32'(n_winc), 32'(exp_winc));
        cmp("winc_vs_handshakes", 32'(n_winc), 32'(n_hs));

        // Single requester 2 streams 0xA0..0xA9: bursts 4,4,2 with bubbles.
        wrst      = 1'b1;
        wfull     = 1'b0;
        arb_en    = 1'b1;
        req_valid = 4'b0000;
        @(posedge wclk);
        #1;
        wrst      = 1'b0;
        k         = 0;
        nw        = 0;
        req_valid = 4'b0100;
        req_data[23:16] = 8'hA0;
        for (int cyc = 0; cyc < 25; cyc++) begin
            @(negedge wclk);
            if (winc) begin
                if (nw < 10) begin
                    wd_q[nw] = wdata;
                    wc_q[nw] = cyc;
                end
                nw++;
            end
            hs = req_valid[2] & req_ready[2];
            @(posedge wclk);
            #1;
            if (hs) k++;
            if (k >= 10) req_valid = 4'b0000;
            else req_data[23:16] = 8'hA0 + 8'(k);
        end
        cmp("stream_word_count", 32'(nw), 32'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < nw) begin
                cmp($sformatf("stream_word%0d {cycle,data}", i),
                    {24'(wc_q[i]), wd_q[i]}, {24'(exp_cyc[i]), 8'hA0 + 8'(i)});
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
